alu_seq: RTL and testbench

Parametrised successor to the team's single-cycle registered ALU. It adds a valid/ready handshake on both sides, a one-deep output register, synchronous reset, a fixed opcode map with SUB and arithmetic shift, and a multi-cycle shift-add multiplier. It sits between the decode stage and writeback. The multiplier can stall issue; backpressure comes from writeback.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_seq_mul.sv | 58 +++++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 tb/tb_alu_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, status bit
// positions, controller state encoding and a status packing helper.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010100;
  localparam logic [5:0] OP_AND = 6'b010101;
  localparam logic [5:0] OP_OR  = 6'b010001;
  localparam logic [5:0] OP_NOR = 6'b010010;
  localparam logic [5:0] OP_XOR = 6'b010011;
  localparam logic [5:0] OP_SRL = 6'b001100;
  localparam logic [5:0] OP_SLL = 6'b001101;
  localparam logic [5:0] OP_SRA = 6'b001110;
  localparam logic [5:0] OP_MUL = 6'b011000;

  localparam int ST_OVER  = 3;
  localparam int ST_CARRY = 2;
  localparam int ST_ZERO  = 1;
  localparam int ST_NEG   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Places the four flags at their fixed positions in the Status word.
  function automatic logic [3:0] packStatus(input logic over, input logic carry,
                                            input logic zero, input logic neg);
    logic [3:0] s;
    s           = 4'b0000;
    s[ST_OVER]  = over;
    s[ST_CARRY] = carry;
    s[ST_ZERO]  = zero;
    s[ST_NEG]   = neg;
    return s;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Unsigned shift-add multiplier. A start pulse captures both operands,
// then one partial product is accumulated per cycle for WIDTH cycles.
// o_done is high during the final accumulation cycle, so the product is
// complete on the cycle after o_done.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;

  // Operand capture on start, then one shift-add step per cycle while busy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy   <= 1'b0;
      r_count  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_count  <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (r_count == LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_count == LAST);
  assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU between decode and writeback: valid/ready on both sides,
// a one-deep registered result, single-cycle logic/arith/shift ops and an
// optional multi-cycle multiplier that stalls issue while it runs.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [5:0]       OPCode,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ResultC,
  output logic [3:0]       Status
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_t           r_state;
  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_status;

  logic               w_accept;
  logic               w_isMul;
  logic               w_mulStart;
  logic               w_mulBusy;
  logic               w_mulDone;
  logic [2*WIDTH-1:0] w_mulProduct;
  logic [WIDTH-1:0]   w_mulResult;
  logic [3:0]         w_mulStatus;
  logic [SHW-1:0]     w_shAmt;
  logic [SHW-1:0]     w_amtM1;
  logic [SHW-1:0]     w_sllIdx;
  logic [WIDTH:0]     w_addSum;
  logic [WIDTH:0]     w_subSum;
  logic [WIDTH-1:0]   w_aluResult;
  logic               w_aluCarry;
  logic               w_aluOver;
  logic [3:0]         w_aluStatus;

  assign InReady    = (r_state == IDLE) && (!r_outValid || OutReady);
  assign w_accept   = InValid && InReady;
  assign w_isMul    = MUL_EN && (OPCode == OP_MUL);
  assign w_mulStart = w_accept && w_isMul;

  // The last bit shifted out sits at index n-1 for right shifts and at
  // WIDTH-n for left shifts; WIDTH-n wraps to ~(n-1) in SHW bits.
  assign w_shAmt  = DataB[SHW-1:0];
  assign w_amtM1  = w_shAmt - 1'b1;
  assign w_sllIdx = ~w_amtM1;

  assign w_addSum = {1'b0, DataA} + {1'b0, DataB};
  assign w_subSum = {1'b0, DataA} + {1'b0, ~DataB} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle datapath; MUL and unknown opcodes fall through to zero here.
  always_comb begin
    w_aluResult = '0;
    w_aluCarry  = 1'b0;
    w_aluOver   = 1'b0;
    case (OPCode)
      OP_ADD: begin
        w_aluResult = w_addSum[WIDTH-1:0];
        w_aluCarry  = w_addSum[WIDTH];
        w_aluOver   = (DataA[MSB] == DataB[MSB]) && (w_addSum[MSB] != DataA[MSB]);
      end
      OP_SUB: begin
        w_aluResult = w_subSum[WIDTH-1:0];
        w_aluCarry  = w_subSum[WIDTH];
        w_aluOver   = (DataA[MSB] != DataB[MSB]) && (w_subSum[MSB] != DataA[MSB]);
      end
      OP_AND: w_aluResult = DataA & DataB;
      OP_OR:  w_aluResult = DataA | DataB;
      OP_NOR: w_aluResult = ~(DataA | DataB);
      OP_XOR: w_aluResult = DataA ^ DataB;
      OP_SRL: begin
        w_aluResult = DataA >> w_shAmt;
        w_aluCarry  = (w_shAmt != '0) && DataA[w_amtM1];
      end
      OP_SLL: begin
        w_aluResult = DataA << w_shAmt;
        w_aluCarry  = (w_shAmt != '0) && DataA[w_sllIdx];
      end
      OP_SRA: begin
        w_aluResult = WIDTH'($signed(DataA) >>> w_shAmt);
        w_aluCarry  = (w_shAmt != '0) && DataA[w_amtM1];
      end
      default: begin
        w_aluResult = '0;
      end
    endcase
  end

  assign w_aluStatus = packStatus(w_aluOver, w_aluCarry, (w_aluResult == '0), w_aluResult[MSB]);

  generate
    if (MUL_EN) begin : g_mul
      alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clock   (Clock),
        .i_reset   (Reset),
        .i_start   (w_mulStart),
        .i_a       (DataA),
        .i_b       (DataB),
        .o_busy    (w_mulBusy),
        .o_done    (w_mulDone),
        .o_product (w_mulProduct)
      );
    end else begin : g_noMul
      assign w_mulBusy    = 1'b0;
      assign w_mulDone    = 1'b0;
      assign w_mulProduct = '0;
    end
  endgenerate

  assign w_mulResult = w_mulProduct[WIDTH-1:0];
  assign w_mulStatus = packStatus(|w_mulProduct[2*WIDTH-1:WIDTH], 1'b0,
                                  (w_mulResult == '0), w_mulResult[MSB]);

  // Controller and output register: drain on OutReady, load single-cycle
  // results on accept, and load the product once the output slot is free.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_status   <= '0;
    end else begin
      if (r_outValid && OutReady) begin
        r_outValid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_isMul) begin
              r_state <= MUL;
            end else begin
              r_result   <= w_aluResult;
              r_status   <= w_aluStatus;
              r_outValid <= 1'b1;
            end
          end
        end
        MUL: begin
          // The idle-multiplier escape keeps the controller from sticking here.
          if (w_mulDone || !w_mulBusy) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!r_outValid || OutReady) begin
            r_result   <= w_mulResult;
            r_status   <= w_mulStatus;
            r_outValid <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign OutValid = r_outValid;
  assign ResultC  = r_result;
  assign Status   = r_status;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int NTX    = 300;
  localparam int MAXCYC = 20000;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [5:0]  OPCode;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] ResultC;
  logic [3:0]  Status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expRes;
    logic [3:0]  expStat;
  } vec_t;

  vec_t vecs[16];
  logic [35:0] expQ[$];

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .OPCode   (OPCode),
    .DataA    (DataA),
    .DataB    (DataB),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .ResultC  (ResultC),
    .Status   (Status)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [5:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    InValid = valid;
    OPCode  = op;
    DataA   = a;
    DataB   = b;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference model computed from the arithmetic meaning of each opcode.
  function automatic logic [35:0] refModel(input logic [5:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wide;
    logic [31:0] res;
    longint      sa, sb, sr;
    logic        c, o;
    int          n;
    n   = int'(b[4:0]);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 32'h0;
    c   = 1'b0;
    o   = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {32'h0, a} + {32'h0, b};
        res  = wide[31:0];
        c    = wide[32];
        sr   = sa + sb;
        o    = (sr != longint'($signed(res)));
      end
      OP_SUB: begin
        res = a - b;
        c   = (a >= b);
        sr  = sa - sb;
        o   = (sr != longint'($signed(res)));
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_NOR: res = ~(a | b);
      OP_XOR: res = a ^ b;
      OP_SRL: begin
        res = a >> n;
        if (n != 0) c = a[n-1];
      end
      OP_SLL: begin
        res = a << n;
        if (n != 0) c = a[32-n];
      end
      OP_SRA: begin
        res = $signed(a) >>> n;
        if (n != 0) c = a[n-1];
      end
      OP_MUL: begin
        wide = {32'h0, a} * {32'h0, b};
        res  = wide[31:0];
        o    = (wide[63:32] != 32'h0);
      end
      default: res = 32'h0;
    endcase
    return {o, c, (res == 32'h0), res[31], res};
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [5:0] randOp();
    logic [5:0] ops[10];
    int k;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR, OP_SRL, OP_SLL, OP_SRA, OP_MUL};
    k = $urandom_range(0, 19);
    if (k < 9)  return ops[k];
    if (k == 9) return OP_MUL;
    if (k == 10) return 6'(($urandom_range(0, 63)));
    return ops[k % 9];
  endfunction

  initial begin
    int bad;
    int sent;
    int cyc;
    logic prevHold;
    logic [35:0] exp;

    vecs[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
    vecs[1]  = '{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
    vecs[2]  = '{OP_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 4'b0001};
    vecs[3]  = '{OP_SRA, 32'h80000001, 32'h00000001, 32'hC0000000, 4'b0101};
    vecs[4]  = '{OP_SLL, 32'h00000001, 32'h00000000, 32'h00000001, 4'b0000};
    vecs[5]  = '{OP_XOR, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 4'b0001};
    vecs[6]  = '{6'b111111, 32'h12345678, 32'h00000009, 32'h00000000, 4'b0010};
    vecs[7]  = '{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
    vecs[8]  = '{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1100};
    vecs[9]  = '{OP_SRL, 32'h00000003, 32'h00000001, 32'h00000001, 4'b0100};
    vecs[10] = '{OP_SLL, 32'h80000000, 32'h00000001, 32'h00000000, 4'b0110};
    vecs[11] = '{OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0001};
    vecs[12] = '{OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0010};
    vecs[13] = '{OP_OR,  32'h12340000, 32'h00005678, 32'h12345678, 4'b0000};
    vecs[14] = '{OP_SRA, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b0001};
    vecs[15] = '{OP_SLL, 32'h00000003, 32'h0000001F, 32'h80000000, 4'b0101};

    Reset    = 1'b1;
    OutReady = 1'b1;
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    step();
    step();
    Reset = 1'b0;
    checkOutput("resetOutValid", 64'(OutValid), 64'(1'b0));
    checkOutput("resetResult", 64'(ResultC), 64'(32'h0));
    checkOutput("resetStatus", 64'(Status), 64'(4'h0));
    checkOutput("resetInReady", 64'(InReady), 64'(1'b1));

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      checkOutput($sformatf("vec%0d_inReady", i), 64'(InReady), 64'(1'b1));
      step();
      checkOutput($sformatf("vec%0d_outValid", i), 64'(OutValid), 64'(1'b1));
      checkOutput($sformatf("vec%0d_result", i), 64'(ResultC), 64'(vecs[i].expRes));
      checkOutput($sformatf("vec%0d_status", i), 64'(Status), 64'(vecs[i].expStat));
    end

    $display("[TB] multiplier latency");
    applyStimulus(1'b1, OP_MUL, 32'h00010000, 32'h00010000);
    step();
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    bad = 0;
    for (int i = 0; i < 33; i++) begin
      if (InReady !== 1'b0 || OutValid !== 1'b0) bad++;
      step();
    end
    checkOutput("mulStallCycles", 64'(bad), 64'(0));
    checkOutput("mulOutValid", 64'(OutValid), 64'(1'b1));
    checkOutput("mulResult", 64'(ResultC), 64'(32'h0));
    checkOutput("mulStatus", 64'(Status), 64'(4'b1010));

    $display("[TB] backpressure hold");
    applyStimulus(1'b1, OP_XOR, 32'hF0F0F0F0, 32'h0F0F0F0F);
    step();
    OutReady = 1'b0;
    applyStimulus(1'b1, OP_ADD, 32'h1, 32'h2);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (OutValid !== 1'b1 || ResultC !== 32'hFFFFFFFF || Status !== 4'b0001 ||
          InReady !== 1'b0) bad++;
      step();
    end
    checkOutput("holdCycles", 64'(bad), 64'(0));
    OutReady = 1'b1;
    #1;
    checkOutput("drainInReady", 64'(InReady), 64'(1'b1));
    step();
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    checkOutput("drainAcceptValid", 64'(OutValid), 64'(1'b1));
    checkOutput("drainAcceptResult", 64'(ResultC), 64'(32'h3));
    checkOutput("drainAcceptStatus", 64'(Status), 64'(4'b0000));
    step();
    checkOutput("drainEmpty", 64'(OutValid), 64'(1'b0));

    $display("[TB] reset during multiply");
    applyStimulus(1'b1, OP_MUL, 32'h00000007, 32'h00000009);
    step();
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checkOutput("abortInReady", 64'(InReady), 64'(1'b1));
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (OutValid !== 1'b0) bad++;
      step();
    end
    checkOutput("abortNoOutput", 64'(bad), 64'(0));
    applyStimulus(1'b1, OP_ADD, 32'h2, 32'h2);
    step();
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    checkOutput("abortRecoverResult", 64'(ResultC), 64'(32'h4));
    step();

    $display("[TB] randomized run");
    sent     = 0;
    cyc      = 0;
    prevHold = 1'b0;
    while ((sent < NTX || expQ.size() != 0) && cyc < MAXCYC) begin
      if (sent < NTX) begin
        applyStimulus($urandom_range(0, 9) < 7, randOp(), randOperand(), randOperand());
      end else begin
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
      end
      OutReady = ($urandom_range(0, 3) != 0);
      #1;
      if (prevHold) checkOutput("randHoldValid", 64'(OutValid), 64'(1'b1));
      if (OutValid && OutReady) begin
        if (expQ.size() == 0) begin
          checkOutput("randUnexpectedOutput", 64'(1'b1), 64'(1'b0));
        end else begin
          exp = expQ.pop_front();
          checkOutput("randResult", 64'({Status, ResultC}), 64'(exp));
        end
      end
      if (InValid && InReady) begin
        expQ.push_back(refModel(OPCode, DataA, DataB));
        sent++;
      end
      prevHold = OutValid && !OutReady;
      step();
      cyc++;
    end
    checkOutput("randSent", 64'(sent), 64'(NTX));
    checkOutput("randDrained", 64'(expQ.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
